sha256_padder: RTL and testbench

SHA256_PADDER -- requirements
Module: sha256_padder

---
 rtl/sha256_padder.sv | 146 ++++++++++++++
 tb/tb_sha256_padder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// sha256_padder: packs a byte stream into 512-bit SHA-256 blocks with 0x80 marker and 64-bit bit length.
// Define SHA256_PADDER_ERROR_EN to add a sticky protocol_error output for bytes offered while busy.
module sha256_padder (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_enable,
    input  logic         input_complete,
    input  logic [7:0]   input_data,
    output logic         in_ready,
    output logic [511:0] block_data,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_last
`ifdef SHA256_PADDER_ERROR_EN
    ,
    output logic         protocol_error
`endif
);

    typedef enum logic [1:0] {LOAD, EMIT, PAD_EXTRA, EMIT_LAST} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0][7:0] r_buf;       // element 63 is message byte 0
    logic [5:0]       r_idx;
    logic [63:0]      r_len;
    logic             r_pend;      // input_complete arrived after a full 64-byte block
    logic             r_extra;     // 0x80 landed too late for the length; one more block needed

    logic             w_wr;
    logic             w_done;
    logic             w_hand;
    logic             w_pend_now;
    logic [6:0]       w_pos;
    logic [63:0]      w_len_nxt;

    always_comb begin
        in_ready    = (r_state == LOAD);
        block_valid = (r_state == EMIT) || (r_state == EMIT_LAST);
        block_last  = (r_state == EMIT_LAST);
        block_data  = r_buf;
        w_wr        = load_enable & in_ready;
        w_done      = input_complete & in_ready;
        w_hand      = block_valid & block_ready;
        // Marker position: after the same-cycle byte, 64 means "spills into a new block"
        w_pos       = {1'b0, r_idx} + {6'd0, w_wr};
        w_len_nxt   = r_len + (w_wr ? 64'd8 : 64'd0);
        w_pend_now  = r_pend | (input_complete & ~r_extra);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD: begin
                if (w_done)
                    w_state_nxt = (w_pos <= 7'd55) ? EMIT_LAST : EMIT;
                else if (w_wr && r_idx == 6'd63)
                    w_state_nxt = EMIT;
            end
            EMIT: begin
                if (w_hand)
                    w_state_nxt = (r_extra || w_pend_now) ? PAD_EXTRA : LOAD;
            end
            PAD_EXTRA: w_state_nxt = EMIT_LAST;
            EMIT_LAST: begin
                if (w_hand)
                    w_state_nxt = LOAD;
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= LOAD;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_pend  <= 1'b0;
            r_extra <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_wr) begin
                        r_buf[6'd63 - r_idx] <= input_data;
                        r_idx                <= r_idx + 6'd1;
                        r_len                <= w_len_nxt;
                    end
                    if (w_done) begin
                        if (w_pos[6])
                            r_pend <= 1'b1;
                        else
                            r_buf[6'd63 - w_pos[5:0]] <= 8'h80;
                        if (w_pos <= 7'd55)
                            r_buf[7:0] <= w_len_nxt;
                        else if (!w_pos[6])
                            r_extra <= 1'b1;
                    end
                end
                EMIT: begin
                    r_pend <= w_pend_now;
                    if (w_hand) begin
                        r_buf <= '0;
                        r_idx <= '0;
                    end
                end
                PAD_EXTRA: begin
                    // Buffer was cleared on handoff; only the tail fields are written
                    r_buf[7:0] <= r_len;
                    if (r_pend)
                        r_buf[63] <= 8'h80;
                end
                EMIT_LAST: begin
                    if (w_hand) begin
                        r_buf   <= '0;
                        r_idx   <= '0;
                        r_len   <= '0;
                        r_pend  <= 1'b0;
                        r_extra <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHA256_PADDER_ERROR_EN
    logic r_err;

    always_ff @(posedge clock) begin
        if (reset)
            r_err <= 1'b0;
        else if (load_enable && !in_ready)
            r_err <= 1'b1;
    end

    assign protocol_error = r_err;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: scoreboard bench; a padding model queues expected blocks, a monitor checks handoffs.
module tb_sha256_padder;

    logic         clock = 1'b0;
    logic         reset;
    logic         load_enable;
    logic         input_complete;
    logic [7:0]   input_data;
    logic         in_ready;
    logic [511:0] block_data;
    logic         block_valid;
    logic         block_ready;
    logic         block_last;
`ifdef SHA256_PADDER_ERROR_EN
    logic         protocol_error;
`endif

    typedef struct {
        logic [511:0] data;
        logic         last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] msg_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    sha256_padder dut (
        .clock          (clock),
        .reset          (reset),
        .load_enable    (load_enable),
        .input_complete (input_complete),
        .input_data     (input_data),
        .in_ready       (in_ready),
        .block_data     (block_data),
        .block_valid    (block_valid),
        .block_ready    (block_ready),
        .block_last     (block_last)
`ifdef SHA256_PADDER_ERROR_EN
        ,
        .protocol_error (protocol_error)
`endif
    );

    always #5 clock = ~clock;

    // Handoffs happen on the next rising edge; sample on the falling edge before it
    always @(negedge clock) begin
        if (reset === 1'b0 && block_valid === 1'b1 && block_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_block: got data=%h last=%b, expected no block", block_data, block_last);
            end else begin
                mon_e = exp_q.pop_front();
                if (block_data !== mon_e.data || block_last !== mon_e.last) begin
                    miscompares++;
                    $display("FAIL block: got data=%h last=%b, expected data=%h last=%b",
                             block_data, block_last, mon_e.data, mon_e.last);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count
    task automatic push_expected();
        logic [7:0]   p[$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        int           nb;
        p = msg_q;
        bitlen = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[b*64+j];
            exp_q.push_back('{data: blk, last: (b == nb-1)});
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end
    endtask

    // mode 0: separate input_complete, 1: complete with last byte, 2: no complete
    task automatic send_msg(input int mode);
        for (int i = 0; i < msg_q.size(); i++) begin
            wait_ready();
            load_enable    = 1'b1;
            input_data     = msg_q[i];
            input_complete = (mode == 1 && i == msg_q.size() - 1);
            tick();
            load_enable    = 1'b0;
            input_complete = 1'b0;
        end
        if (mode == 0 || (mode == 1 && msg_q.size() == 0)) begin
            wait_ready();
            input_complete = 1'b1;
            tick();
            input_complete = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_ready !== 1'b1) && n < 1000) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d blocks outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_enable = 1'b0;
        input_complete = 1'b0;
        input_data = 8'h00;
        block_ready = 1'b1;
        tick();
        tick();
        vectors++;
        if (block_valid !== 1'b0 || block_last !== 1'b0 || block_data !== 512'h0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b last=%b in_ready=%b data_nonzero=%b, expected 0 0 1 0",
                     block_valid, block_last, in_ready, block_data != 512'h0);
        end
`ifdef SHA256_PADDER_ERROR_EN
        vectors++;
        if (protocol_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_error: protocol_error=%b, expected 0", protocol_error);
        end
`endif
        reset = 1'b0;
        tick();
    endtask

    task automatic test_goirish();
        msg_q = '{8'h67, 8'h6f, 8'h69, 8'h72, 8'h69, 8'h73, 8'h68, 8'h0a};
        exp_q.push_back('{data: {64'h676f69726973680a, 8'h80, 376'h0, 64'h40}, last: 1'b1});
        send_msg(0);
        vectors++;
        if (block_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL goirish_latency: block_valid=%b one cycle after complete, expected 1", block_valid);
        end
        drain();
    endtask

    task automatic test_empty();
        msg_q.delete();
        exp_q.push_back('{data: {8'h80, 504'h0}, last: 1'b1});
        send_msg(0);
        vectors++;
        if (block_valid !== 1'b1 || block_last !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_latency: valid=%b last=%b, expected 1 1", block_valid, block_last);
        end
        drain();
    endtask

    task automatic test_boundary_55_56();
        msg_q.delete();
        for (int i = 0; i < 55; i++) msg_q.push_back(8'h61);
        push_expected();
        send_msg(1);
        drain();
        msg_q.push_back(8'h61);
        push_expected();
        send_msg(1);
        drain();
    endtask

    task automatic test_full_then_pending();
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'h61);
        push_expected();
        block_ready = 1'b0;
        send_msg(2);
        input_complete = 1'b1;
        tick();
        input_complete = 1'b0;
        vectors++;
        if (block_valid !== 1'b1 || block_last !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_hold: valid=%b last=%b in_ready=%b, expected 1 0 0",
                     block_valid, block_last, in_ready);
        end
        block_ready = 1'b1;
        drain();
    endtask

    task automatic test_stall();
        msg_q = '{8'h61, 8'h62, 8'h63};
        push_expected();
        block_ready = 1'b0;
        send_msg(0);
        for (int k = 0; k < 10; k++) begin
            load_enable = 1'b1;
            input_data  = 8'hee;
            tick();
            vectors++;
            if (exp_q.size() == 0 || block_valid !== 1'b1 || in_ready !== 1'b0 ||
                block_last !== 1'b1 || block_data !== exp_q[0].data) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d: valid=%b in_ready=%b last=%b data=%h, expected 1 0 1 stable block",
                         k, block_valid, in_ready, block_last, block_data);
            end
        end
        load_enable = 1'b0;
`ifdef SHA256_PADDER_ERROR_EN
        vectors++;
        if (protocol_error !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_error: protocol_error=%b, expected 1", protocol_error);
        end
`endif
        block_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid();
        msg_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        send_msg(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (block_valid !== 1'b0 || in_ready !== 1'b1 || block_data !== 512'h0) begin
            miscompares++;
            $display("FAIL reset_mid_msg: valid=%b in_ready=%b data_nonzero=%b, expected 0 1 0",
                     block_valid, in_ready, block_data != 512'h0);
        end
`ifdef SHA256_PADDER_ERROR_EN
        vectors++;
        if (protocol_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_clears_error: protocol_error=%b, expected 0", protocol_error);
        end
`endif
        msg_q = '{8'h61, 8'h62, 8'h63};
        exp_q.push_back('{data: {32'h61626380, 416'h0, 64'h18}, last: 1'b1});
        send_msg(0);
        drain();
        // Abandon a block that is already being offered
        msg_q = '{8'h78, 8'h79, 8'h7a};
        block_ready = 1'b0;
        send_msg(0);
        reset = 1'b1;
        block_ready = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (block_valid !== 1'b0 || block_data !== 512'h0) begin
            miscompares++;
            $display("FAIL reset_mid_handoff: valid=%b data_nonzero=%b, expected 0 0",
                     block_valid, block_data != 512'h0);
        end
        for (int k = 0; k < 5; k++) tick();
    endtask

    task automatic test_back_to_back();
        int lens[12] = '{0, 1, 54, 57, 63, 64, 65, 119, 120, 128, 0, 0};
        lens[10] = $urandom_range(0, 140);
        lens[11] = $urandom_range(0, 140);
        for (int m = 0; m < 12; m++) begin
            msg_q.delete();
            for (int i = 0; i < lens[m]; i++) msg_q.push_back(8'($urandom_range(0, 255)));
            push_expected();
            send_msg(m % 2);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_goirish();
        test_empty();
        test_boundary_55_56();
        test_full_then_pending();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
